// File: rtl/aes_io_loader.sv
// aes_io_loader: bus front-end for the AES round-control FSM.
// Takes a per-operation configuration, streams in the key and one 128-bit block
// over a 32-bit valid/ready port, starts the FSM, and then streams the 128-bit
// result back out as four words, most significant first.
// Optional feature: define AES_IO_KEY_REUSE_EN to let an operation skip the key
// load and reuse the key already held, provided the mode is unchanged.
module aes_io_loader #(
  parameter int WORD_W = 32,
  parameter int KEY_W  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_enc_dec,
  input  logic              cfg_key_reuse,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              aes_start,
  output logic [1:0]        aes_mode,
  output logic              aes_enc_dec,
  output logic [3:0]        aes_round_amount,
  output logic [KEY_W-1:0]  aes_key,
  output logic [127:0]      aes_block,
  input  logic              aes_done,
  input  logic [127:0]      aes_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_KEY  = 3'd1,
    S_LOAD_DATA = 3'd2,
    S_START     = 3'd3,
    S_WAIT      = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [1:0]          r_mode;
  logic                r_enc_dec;
  logic [3:0]          r_rounds;
  logic [KEY_W-1:0]    r_key;
  logic [127:0]        r_block;
  logic [127:0]        r_result;
  logic [2:0]          r_wcnt;
  logic [1:0]          r_ocnt;
  logic                r_err;

  logic                w_cfg_hs;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_mode_legal;
  logic                w_reuse_go;
  logic                w_reuse_bad;
  logic                w_set_err;
  logic                w_cfg_accept;
  logic [2:0]          w_key_last;

  // Number of full AES rounds for each legal mode; the illegal code never gets stored.
  function automatic logic [3:0] f_rounds(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4'd10;
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Handshakes are decoded from the state directly so they do not loop through the ready outputs.
  assign w_cfg_hs     = cfg_valid & reset & (r_state == S_IDLE);
  assign w_in_hs      = in_valid & ((r_state == S_LOAD_KEY) | (r_state == S_LOAD_DATA));
  assign w_out_hs     = out_ready & (r_state == S_DRAIN);
  assign w_mode_legal = (cfg_mode != 2'b11);

  // Index of the final key word: 3, 5 or 7 for 4, 6 or 8 key words.
  assign w_key_last   = {r_mode, 1'b1} + 3'd2;

`ifdef AES_IO_KEY_REUSE_EN
  logic r_key_valid;

  // A key counts as loaded once its final word has been accepted; only reset forgets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_valid <= 1'b0;
    end else if (w_in_hs && (r_state == S_LOAD_KEY) && (r_wcnt == w_key_last)) begin
      r_key_valid <= 1'b1;
    end
  end

  assign w_reuse_go  = cfg_key_reuse & r_key_valid & (cfg_mode == r_mode);
  assign w_reuse_bad = cfg_key_reuse & r_key_valid & (cfg_mode != r_mode);
`else
  logic w_unused_key_reuse;

  assign w_unused_key_reuse = cfg_key_reuse;
  assign w_reuse_go         = 1'b0;
  assign w_reuse_bad        = 1'b0;
`endif

  assign w_set_err    = w_cfg_hs & (~w_mode_legal | w_reuse_bad);
  assign w_cfg_accept = w_cfg_hs & ~w_set_err;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the state-driven bus/control outputs.
  always_comb begin
    w_next    = r_state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    aes_start = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (r_state)
      S_IDLE: begin
        // Held low while reset is asserted so every output reads zero during reset.
        cfg_ready = reset;
        if (w_cfg_accept) begin
          w_next = w_reuse_go ? S_LOAD_DATA : S_LOAD_KEY;
        end
      end
      S_LOAD_KEY: begin
        in_ready = 1'b1;
        if (w_in_hs && (r_wcnt == w_key_last)) begin
          w_next = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        in_ready = 1'b1;
        if (w_in_hs && (r_wcnt == 3'd3)) begin
          w_next = S_START;
        end
      end
      S_START: begin
        aes_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (aes_done) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (r_ocnt == 2'd3);
        case (r_ocnt)
          2'd0:    out_data = r_result[127:96];
          2'd1:    out_data = r_result[95:64];
          2'd2:    out_data = r_result[63:32];
          default: out_data = r_result[31:0];
        endcase
        if (w_out_hs && (r_ocnt == 2'd3)) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Per-operation configuration; left untouched by rejected handshakes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= 2'b00;
      r_enc_dec <= 1'b0;
      r_rounds  <= 4'd0;
    end else if (w_cfg_accept) begin
      r_mode    <= cfg_mode;
      r_enc_dec <= cfg_enc_dec;
      r_rounds  <= f_rounds(cfg_mode);
    end
  end

  // Sticky error: illegal mode, or a key reuse whose mode differs from the held key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

  // Input word counter restarts on every state change and counts accepted words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt <= 3'd0;
    end else if (w_next != r_state) begin
      r_wcnt <= 3'd0;
    end else if (w_in_hs) begin
      r_wcnt <= r_wcnt + 3'd1;
    end
  end

  // Key register: first word also clears the LSBs that shorter keys leave unused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key <= '0;
    end else if (w_in_hs && (r_state == S_LOAD_KEY)) begin
      if (r_wcnt == 3'd0) begin
        r_key <= {in_data, {(KEY_W-WORD_W){1'b0}}};
      end else begin
        for (int k = 1; k < 8; k++) begin
          if (r_wcnt == 3'(k)) begin
            r_key[KEY_W-1-WORD_W*k -: WORD_W] <= in_data;
          end
        end
      end
    end
  end

  // Data block register, most significant word arrives first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_block <= '0;
    end else if (w_in_hs && (r_state == S_LOAD_DATA)) begin
      for (int k = 0; k < 4; k++) begin
        if (r_wcnt == 3'(k)) begin
          r_block[127-WORD_W*k -: WORD_W] <= in_data;
        end
      end
    end
  end

  // Result capture on done (only while waiting) and the output word index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_ocnt   <= 2'd0;
    end else begin
      if ((r_state == S_WAIT) && aes_done) begin
        r_result <= aes_result;
      end
      // Two-bit index wraps back to zero on the final handshake.
      if (w_out_hs) begin
        r_ocnt <= r_ocnt + 2'd1;
      end
    end
  end

  assign aes_mode         = r_mode;
  assign aes_enc_dec      = r_enc_dec;
  assign aes_round_amount = r_rounds;
  assign aes_key          = r_key;
  assign aes_block        = r_block;
  assign busy             = (r_state != S_IDLE);
  assign err              = r_err;

endmodule

// File: tb/tb_aes_io_loader.sv
// Directed bench for aes_io_loader: configuration, key/data streaming, start
// pulse, result drain with back-pressure, illegal mode, reset abort and key reuse.
module tb_aes_io_loader;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic          cfg_enc_dec;
  logic          cfg_key_reuse;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          aes_start;
  logic [1:0]    aes_mode;
  logic          aes_enc_dec;
  logic [3:0]    aes_round_amount;
  logic [255:0]  aes_key;
  logic [127:0]  aes_block;
  logic          aes_done;
  logic [127:0]  aes_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  int in_hs_cnt = 0;
  int start_cnt = 0;

  aes_io_loader #(.WORD_W(32), .KEY_W(256)) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_mode         (cfg_mode),
    .cfg_enc_dec      (cfg_enc_dec),
    .cfg_key_reuse    (cfg_key_reuse),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .aes_start        (aes_start),
    .aes_mode         (aes_mode),
    .aes_enc_dec      (aes_enc_dec),
    .aes_round_amount (aes_round_amount),
    .aes_key          (aes_key),
    .aes_block        (aes_block),
    .aes_done         (aes_done),
    .aes_result       (aes_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Count input handshakes and start pulses mid-cycle, when all signals are settled.
  always @(negedge clk) begin
    if (in_valid && in_ready) in_hs_cnt++;
    if (aes_start) start_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic ed, input logic ru);
    bit hs = 1'b0;
    int n = 0;
    cfg_valid = 1'b1; cfg_mode = m; cfg_enc_dec = ed; cfg_key_reuse = ru;
    while (!hs && n < 50) begin
      @(negedge clk); hs = cfg_ready;
      @(posedge clk); #1; n++;
    end
    cfg_valid = 1'b0; cfg_key_reuse = 1'b0;
    chk("cfg_handshake", hs, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    bit hs = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!hs && n < 50) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("in_handshake", hs, 1);
    repeat (gap) tick;
  endtask

  // Round-control FSM stand-in: done pulse carrying the result after a latency.
  task automatic fsm_respond(input logic [127:0] res, input int lat);
    repeat (lat) tick;
    aes_done = 1'b1; aes_result = res;
    tick;
    aes_done = 1'b0; aes_result = 128'hbadbadbad_0000_1111_2222_3333_44;
  endtask

  task automatic drain(input logic [127:0] exp, input int stall);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = out_valid;
      if (!seen) begin @(posedge clk); #1; end
      n++;
    end
    chk("out_valid_seen", seen, 1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp[127:96]);
      chk("stall_busy", busy, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("out_data", out_data, exp[127-32*j -: 32]);
      chk("out_last", out_last, (j == 3));
      chk("busy_drain", busy, 1);
      @(posedge clk); #1;
      if (j < 3) @(negedge clk);
    end
    out_ready = 1'b0;
    chk("busy_after_drain", busy, 0);
    chk("cfg_ready_after_drain", cfg_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key1, pt1, res1, blk2, res2, blk3, res3, key5, pt5, res5;
    logic [255:0] key256;
    logic [191:0] key192;
    int base, sbase;

    key1   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    pt1    = 128'h00112233_44556677_8899aabb_ccddeeff;
    res1   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    key256 = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
    blk2   = 128'hdeadbeef_cafef00d_01020304_a5a55a5a;
    res2   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    key192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    blk3   = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
    res3   = 128'hbd334f1d_6e45f25f_f712a214_571fa5cc;
    key5   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    pt5    = 128'h3243f6a8_885a308d_313198a2_e0370734;
    res5   = 128'h3925841d_02dc09fb_dc118597_196a0b32;

    reset = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_enc_dec = 1'b0;
    cfg_key_reuse = 1'b0; in_valid = 1'b0; in_data = '0; aes_done = 1'b0;
    aes_result = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_key", aes_key, 0);
    chk("rst_block", aes_block, 0);
    chk("rst_rounds", aes_round_amount, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_start", aes_start, 0);
    reset = 1'b1;
    tick;
    chk("idle_cfg_ready", cfg_ready, 1);

    // Stray done in IDLE must not start a drain
    aes_done = 1'b1; aes_result = res2;
    tick;
    aes_done = 1'b0;
    tick;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_out_valid", out_valid, 0);

    // AES128 encrypt, FIPS-197 vector
    base = in_hs_cnt; sbase = start_cnt;
    send_cfg(2'b00, 1'b0, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_rounds", aes_round_amount, 10);
    chk("t1_mode", aes_mode, 0);
    chk("t1_enc_dec", aes_enc_dec, 0);
    for (int k = 0; k < 4; k++) send_word(key1[127-32*k -: 32], 0);
    for (int k = 0; k < 4; k++) send_word(pt1[127-32*k -: 32], 0);
    chk("t1_start_pulse", aes_start, 1);
    chk("t1_key", aes_key, {key1, 128'h0});
    chk("t1_block", aes_block, pt1);
    in_valid = 1'b1; in_data = 32'hdeadbeef;
    tick;
    chk("t1_start_fall", aes_start, 0);
    chk("t1_wait_in_ready", in_ready, 0);
    chk("t1_wait_cfg_ready", cfg_ready, 0);
    fsm_respond(res1, 2);
    in_valid = 1'b0;
    drain(res1, 0);
    chk("t1_in_words", in_hs_cnt - base, 8);
    chk("t1_start_count", start_cnt - sbase, 1);

    // AES256 decrypt, in_valid toggling, output back-pressure
    base = in_hs_cnt; sbase = start_cnt;
    send_cfg(2'b10, 1'b1, 1'b0);
    chk("t2_rounds", aes_round_amount, 14);
    chk("t2_enc_dec", aes_enc_dec, 1);
    chk("t2_mode", aes_mode, 2);
    for (int k = 0; k < 8; k++) send_word(key256[255-32*k -: 32], 1);
    for (int k = 0; k < 4; k++) send_word(blk2[127-32*k -: 32], (k < 3) ? 1 : 0);
    chk("t2_start_pulse", aes_start, 1);
    chk("t2_key", aes_key, key256);
    chk("t2_block", aes_block, blk2);
    tick;
    fsm_respond(res2, 4);
    drain(res2, 5);
    chk("t2_in_words", in_hs_cnt - base, 12);
    chk("t2_start_count", start_cnt - sbase, 1);
    chk("t2_key_held", aes_key, key256);
    chk("t2_enc_dec_held", aes_enc_dec, 1);

    // Illegal mode, then a legal AES192 op with err still set
    send_cfg(2'b11, 1'b0, 1'b0);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_cfg_ready", cfg_ready, 1);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_mode_kept", aes_mode, 2);
    base = in_hs_cnt;
    send_cfg(2'b01, 1'b0, 1'b0);
    chk("t3_busy_legal", busy, 1);
    chk("t3_rounds", aes_round_amount, 12);
    chk("t3_err_sticky", err, 1);
    for (int k = 0; k < 6; k++) send_word(key192[191-32*k -: 32], 0);
    for (int k = 0; k < 4; k++) send_word(blk3[127-32*k -: 32], 0);
    chk("t3_start_pulse", aes_start, 1);
    chk("t3_key", aes_key, {key192, 64'h0});
    tick;
    fsm_respond(res3, 1);
    drain(res3, 0);
    chk("t3_in_words", in_hs_cnt - base, 10);
    chk("t3_err_end", err, 1);

    // Reset mid key load
    send_cfg(2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send_word(32'ha0a0a0a0 + k, 0);
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_cfg_ready", cfg_ready, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_err", err, 0);
    chk("t5_key", aes_key, 0);
    chk("t5_block", aes_block, 0);
    chk("t5_enc_dec", aes_enc_dec, 0);
    chk("t5_rounds", aes_round_amount, 0);
    chk("t5_out_data", out_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick;
    base = in_hs_cnt;
    send_cfg(2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_word(key5[127-32*k -: 32], 0);
    for (int k = 0; k < 4; k++) send_word(pt5[127-32*k -: 32], 0);
    chk("t5_start_pulse", aes_start, 1);
    chk("t5_new_key", aes_key, {key5, 128'h0});
    chk("t5_new_block", aes_block, pt5);
    tick;
    fsm_respond(res5, 2);
    drain(res5, 0);
    chk("t5_in_words", in_hs_cnt - base, 8);

`ifdef AES_IO_KEY_REUSE_EN
    // AES192 full load, then reuse the key
    send_cfg(2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) send_word(key192[191-32*k -: 32], 0);
    for (int k = 0; k < 4; k++) send_word(blk3[127-32*k -: 32], 0);
    tick;
    fsm_respond(res3, 1);
    drain(res3, 0);
    base = in_hs_cnt;
    send_cfg(2'b01, 1'b1, 1'b1);
    chk("t6_busy", busy, 1);
    chk("t6_enc_dec", aes_enc_dec, 1);
    for (int k = 0; k < 4; k++) send_word(blk2[127-32*k -: 32], 0);
    chk("t6_start_pulse", aes_start, 1);
    chk("t6_in_words", in_hs_cnt - base, 4);
    chk("t6_key_kept", aes_key, {key192, 64'h0});
    chk("t6_block", aes_block, blk2);
    tick;
    fsm_respond(res2, 1);
    drain(res2, 0);
    chk("t6_err_before", err, 0);
    send_cfg(2'b00, 1'b0, 1'b1);
    chk("t6_err_mode_diff", err, 1);
    chk("t6_busy_mode_diff", busy, 0);
`else
    // Key reuse request is ignored: a full key is still loaded
    base = in_hs_cnt;
    send_cfg(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send_word(key1[127-32*k -: 32], 0);
    chk("t6_no_start_after_4", aes_start, 0);
    chk("t6_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) send_word(pt5[127-32*k -: 32], 0);
    chk("t6_start_pulse", aes_start, 1);
    chk("t6_key_reloaded", aes_key, {key1, 128'h0});
    chk("t6_in_words", in_hs_cnt - base, 8);
    tick;
    fsm_respond(res1, 1);
    drain(res1, 0);
    chk("t6_err", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
